// File: rtl/gol_generation_sequencer_if.sv
// Engine-side handshake bundle: start/initialize/reset strobes, buffer
// addresses and the completion level returned by the Game of Life engine.
interface gol_generation_sequencer_if #(
    parameter int ADDR_W = 12
);
    logic              eng_reset;
    logic              eng_initialize;
    logic              eng_start;
    logic [ADDR_W-1:0] eng_start_address;
    logic [ADDR_W-1:0] eng_result_address;
    logic              eng_completed;

    modport master (
        output eng_reset,
        output eng_initialize,
        output eng_start,
        output eng_start_address,
        output eng_result_address,
        input  eng_completed
    );

    modport slave (
        input  eng_reset,
        input  eng_initialize,
        input  eng_start,
        input  eng_start_address,
        input  eng_result_address,
        output eng_completed
    );
endinterface

// File: rtl/gol_generation_sequencer.sv
// Runs the Game of Life engine for a programmed number of generations,
// ping-ponging source/destination buffers, with a per-phase watchdog.
module gol_generation_sequencer #(
    parameter int ADDR_W       = 12,
    parameter int GEN_W        = 16,
    parameter int TIMEOUT_W    = 26,
    parameter int TIMEOUT      = 50000000,
    parameter int RESET_CYCLES = 4
) (
    input  logic                       fpga_clk_50,
    input  logic                       hps_fpga_reset_n,
    input  logic                       cmd_go,
    input  logic                       cmd_abort,
    input  logic [ADDR_W-1:0]          cfg_buf_a_addr,
    input  logic [ADDR_W-1:0]          cfg_buf_b_addr,
    input  logic [GEN_W-1:0]           cfg_gen_count,
    gol_generation_sequencer_if.master eng,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout_err,
    output logic [GEN_W-1:0]           gen_done,
    output logic                       result_sel
);
    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

    typedef enum logic [2:0] {
        ABORT, IDLE, INIT, SETUP, RUN, RELEASE, DONE, ERROR
    } state_t;

    state_t               state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic [GEN_W-1:0]     cnt_q, cnt_d;
    logic [GEN_W-1:0]     gen_d, gen_inc;
    logic [ADDR_W-1:0]    src_d, dst_d;
    logic                 sel_d;
    logic                 go_prev_q;
    logic                 go_edge;
    logic                 in_phase;
    logic                 timeout_hit;

    always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
        if (!hps_fpga_reset_n) begin
            state_q                <= ABORT;
            hold_q                 <= '0;
            wd_q                   <= '0;
            cnt_q                  <= '0;
            go_prev_q              <= 1'b1;
            gen_done               <= '0;
            result_sel             <= 1'b0;
            eng.eng_start_address  <= '0;
            eng.eng_result_address <= '0;
            eng.eng_reset          <= 1'b1;
            eng.eng_initialize     <= 1'b0;
            eng.eng_start          <= 1'b0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            timeout_err            <= 1'b0;
        end else begin
            state_q                <= state_d;
            hold_q                 <= hold_d;
            wd_q                   <= wd_d;
            cnt_q                  <= cnt_d;
            go_prev_q              <= cmd_go;
            gen_done               <= gen_d;
            result_sel             <= sel_d;
            eng.eng_start_address  <= src_d;
            eng.eng_result_address <= dst_d;
            // Outputs are registered images of the state being entered.
            eng.eng_reset          <= (state_d == ABORT) || (state_d == ERROR);
            eng.eng_initialize     <= (state_d == INIT);
            eng.eng_start          <= (state_d == RUN);
            busy                   <= (state_d == INIT) || (state_d == SETUP) ||
                                      (state_d == RUN)  || (state_d == RELEASE);
            done                   <= (state_d == DONE);
            timeout_err            <= (state_d == ERROR);
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        gen_d       = gen_done;
        sel_d       = result_sel;
        src_d       = eng.eng_start_address;
        dst_d       = eng.eng_result_address;
        go_edge     = cmd_go && !go_prev_q;
        in_phase    = (state_q == RUN) || (state_q == RELEASE);
        // Watchdog spans RUN and RELEASE together; any other state clears it.
        wd_d        = in_phase ? wd_q + 1'b1 : '0;
        timeout_hit = in_phase && (wd_q == TIMEOUT_W'(TIMEOUT - 1));
        gen_inc     = (&gen_done) ? gen_done : gen_done + 1'b1;

        if (cmd_abort && (state_q != ABORT)) begin
            state_d = ABORT;
            hold_d  = '0;
        end else begin
            case (state_q)
                ABORT: begin
                    if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
                        state_d = IDLE;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                IDLE, DONE: begin
                    if (go_edge) begin
                        cnt_d   = cfg_gen_count;
                        gen_d   = '0;
                        sel_d   = 1'b0;
                        src_d   = cfg_buf_a_addr;
                        dst_d   = cfg_buf_b_addr;
                        state_d = (cfg_gen_count == '0) ? DONE : INIT;
                    end
                end
                INIT:  state_d = SETUP;
                SETUP: state_d = RUN;
                RUN: begin
                    if (timeout_hit) begin
                        state_d = ERROR;
                    end else if (eng.eng_completed) begin
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (timeout_hit) begin
                        state_d = ERROR;
                    end else if (!eng.eng_completed) begin
                        gen_d   = gen_inc;
                        sel_d   = ~result_sel;
                        src_d   = eng.eng_result_address;
                        dst_d   = eng.eng_start_address;
                        state_d = (gen_inc == cnt_q) ? DONE : SETUP;
                    end
                end
                ERROR:   state_d = ERROR;
                default: state_d = ABORT;
            endcase
        end
    end
endmodule

// File: tb/tb_gol_generation_sequencer.sv
// Bench for gol_generation_sequencer: table-driven runs against an engine
// model, an address-pair scoreboard, and watchdog/abort corner cases.
`timescale 1ns/1ps
module tb_gol_generation_sequencer;
    localparam int ADDR_W = 12;
    localparam int GEN_W  = 16;

    logic              fpga_clk_50 = 1'b0;
    logic              hps_fpga_reset_n;
    logic              cmd_go;
    logic              cmd_abort;
    logic [ADDR_W-1:0] cfg_buf_a_addr;
    logic [ADDR_W-1:0] cfg_buf_b_addr;
    logic [GEN_W-1:0]  cfg_gen_count;
    logic              busy;
    logic              done;
    logic              timeout_err;
    logic [GEN_W-1:0]  gen_done;
    logic              result_sel;

    gol_generation_sequencer_if #(.ADDR_W(ADDR_W)) eng_if ();

    gol_generation_sequencer #(
        .ADDR_W(ADDR_W), .GEN_W(GEN_W), .TIMEOUT_W(26), .TIMEOUT(100), .RESET_CYCLES(4)
    ) dut (
        .fpga_clk_50      (fpga_clk_50),
        .hps_fpga_reset_n (hps_fpga_reset_n),
        .cmd_go           (cmd_go),
        .cmd_abort        (cmd_abort),
        .cfg_buf_a_addr   (cfg_buf_a_addr),
        .cfg_buf_b_addr   (cfg_buf_b_addr),
        .cfg_gen_count    (cfg_gen_count),
        .eng              (eng_if),
        .busy             (busy),
        .done             (done),
        .timeout_err      (timeout_err),
        .gen_done         (gen_done),
        .result_sel       (result_sel)
    );

    always #10 fpga_clk_50 = ~fpga_clk_50;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
        logic [GEN_W-1:0]  cnt;
        logic [GEN_W-1:0]  exp_gen;
        logic              exp_sel;
        int                exp_inits;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
    } pair_t;

    pair_t sb_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    init_cnt;
    int    start_cnt;
    int    st_cnt;
    int    rel_cnt;
    logic  start_prev;
    bit    eng_hang;
    bit    abort_at_gen1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Generation k reads A/writes B when k is even, the reverse when odd.
    task automatic push_pairs(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b, input int n);
        for (int k = 0; k < n; k++) begin
            pair_t p;
            p.src = (k % 2 == 0) ? a : b;
            p.dst = (k % 2 == 0) ? b : a;
            sb_q.push_back(p);
        end
    endtask

    // One clock: sample DUT on the falling edge, then advance the engine model.
    task automatic tick();
        pair_t p;
        @(negedge fpga_clk_50);
        if (eng_if.eng_initialize) init_cnt++;
        check("init_start_exclusive", 32'(eng_if.eng_initialize & eng_if.eng_start), 0);
        if (eng_if.eng_start && !start_prev) begin
            start_cnt++;
            check("init_before_start", init_cnt, 1);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_start: got start #%0d at 0x%0h, expected none",
                         start_cnt, eng_if.eng_start_address);
            end else begin
                p = sb_q.pop_front();
                check("start_address", 32'(eng_if.eng_start_address), 32'(p.src));
                check("result_address", 32'(eng_if.eng_result_address), 32'(p.dst));
            end
        end
        start_prev = eng_if.eng_start;

        if (!hps_fpga_reset_n) begin
            eng_if.eng_completed = 1'b0;
            st_cnt  = 0;
            rel_cnt = 0;
        end else if (eng_if.eng_start) begin
            rel_cnt = 0;
            if (!eng_hang && !eng_if.eng_completed) begin
                st_cnt++;
                if (st_cnt >= 10) begin
                    eng_if.eng_completed = 1'b1;
                    if (abort_at_gen1 && gen_done == 1) begin
                        cmd_abort     = 1'b1;
                        abort_at_gen1 = 1'b0;
                    end
                end
            end
        end else begin
            st_cnt = 0;
            if (eng_if.eng_completed) begin
                rel_cnt++;
                if (rel_cnt >= 2) begin
                    eng_if.eng_completed = 1'b0;
                    rel_cnt = 0;
                end
            end
        end
    endtask

    task automatic go_pulse();
        cmd_go = 1'b0;
        tick();
        init_cnt  = 0;
        start_cnt = 0;
        cmd_go    = 1'b1;
        tick();
        cmd_go    = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int guard = 0;
        while (!done && guard < bound) begin
            tick();
            guard++;
        end
        check("run_finished", 32'(done), 1);
    endtask

    task automatic run_vec(input vec_t v);
        cfg_buf_a_addr = v.a;
        cfg_buf_b_addr = v.b;
        cfg_gen_count  = v.cnt;
        push_pairs(v.a, v.b, int'(v.cnt));
        go_pulse();
        check("go_busy", 32'(busy), 32'(v.cnt != 0));
        check("go_done", 32'(done), 32'(v.cnt == 0));
        wait_done(40 * int'(v.cnt) + 20);
        check("final_gen_done", 32'(gen_done), 32'(v.exp_gen));
        check("final_result_sel", 32'(result_sel), 32'(v.exp_sel));
        check("init_pulses", init_cnt, v.exp_inits);
        check("start_pulses", start_cnt, 32'(v.cnt));
        check("sb_drained", sb_q.size(), 0);
        check("final_busy", 32'(busy), 0);
        repeat (3) tick();
    endtask

    initial begin
        vec_t vecs[5];
        int   guard;

        vecs[0] = '{a: 12'h000, b: 12'h800, cnt: 16'd0, exp_gen: 16'd0, exp_sel: 1'b0, exp_inits: 0};
        vecs[1] = '{a: 12'h000, b: 12'h800, cnt: 16'd3, exp_gen: 16'd3, exp_sel: 1'b1, exp_inits: 1};
        vecs[2] = '{a: 12'h123, b: 12'h456, cnt: 16'd1, exp_gen: 16'd1, exp_sel: 1'b1, exp_inits: 1};
        vecs[3] = '{a: 12'hABC, b: 12'h010, cnt: 16'd2, exp_gen: 16'd2, exp_sel: 1'b0, exp_inits: 1};
        vecs[4] = '{a: 12'h7FF, b: 12'hFFF, cnt: 16'd4, exp_gen: 16'd4, exp_sel: 1'b0, exp_inits: 1};

        hps_fpga_reset_n     = 1'b0;
        cmd_go               = 1'b1;
        cmd_abort            = 1'b0;
        cfg_buf_a_addr       = '0;
        cfg_buf_b_addr       = '0;
        cfg_gen_count        = '0;
        eng_if.eng_completed = 1'b0;
        eng_hang             = 1'b0;
        abort_at_gen1        = 1'b0;
        start_prev           = 1'b0;
        init_cnt             = 0;
        start_cnt            = 0;
        st_cnt               = 0;
        rel_cnt              = 0;

        // Reset state, with cmd_go already high.
        repeat (3) tick();
        check("rst_eng_reset", 32'(eng_if.eng_reset), 1);
        check("rst_eng_start", 32'(eng_if.eng_start), 0);
        check("rst_eng_init", 32'(eng_if.eng_initialize), 0);
        check("rst_start_addr", 32'(eng_if.eng_start_address), 0);
        check("rst_result_addr", 32'(eng_if.eng_result_address), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_gen_done", 32'(gen_done), 0);
        check("rst_result_sel", 32'(result_sel), 0);

        hps_fpga_reset_n = 1'b1;
        check("rst_hold_c0", 32'(eng_if.eng_reset), 1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("rst_hold_c%0d", i), 32'(eng_if.eng_reset), 32'(i < 4));
        end
        repeat (5) tick();
        check("held_go_no_run_busy", 32'(busy), 0);
        check("held_go_no_run_init", init_cnt, 0);
        check("held_go_no_run_done", 32'(done), 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Go edge and config changes mid-run must not disturb the latched run.
        cfg_buf_a_addr = 12'h100;
        cfg_buf_b_addr = 12'h200;
        cfg_gen_count  = 16'd3;
        push_pairs(12'h100, 12'h200, 3);
        go_pulse();
        guard = 0;
        while (start_cnt < 1 && guard < 20) begin
            tick();
            guard++;
        end
        cfg_buf_a_addr = 12'hFFF;
        cfg_buf_b_addr = 12'hEEE;
        cfg_gen_count  = 16'd1;
        cmd_go = 1'b1;
        repeat (2) tick();
        cmd_go = 1'b0;
        check("midrun_busy", 32'(busy), 1);
        wait_done(200);
        check("midrun_gen_done", 32'(gen_done), 3);
        check("midrun_result_sel", 32'(result_sel), 1);
        check("midrun_init_pulses", init_cnt, 1);
        check("midrun_start_pulses", start_cnt, 3);
        check("midrun_sb_drained", sb_q.size(), 0);
        repeat (3) tick();

        // Watchdog: engine never completes.
        eng_hang       = 1'b1;
        cfg_buf_a_addr = 12'h020;
        cfg_buf_b_addr = 12'h040;
        cfg_gen_count  = 16'd2;
        push_pairs(12'h020, 12'h040, 1);
        go_pulse();
        guard = 0;
        while (start_cnt < 1 && guard < 20) begin
            tick();
            guard++;
        end
        check("wd_start_seen", start_cnt, 1);
        guard = 0;
        while (!timeout_err && guard < 300) begin
            tick();
            guard++;
        end
        check("wd_latency", guard, 100);
        check("wd_eng_start", 32'(eng_if.eng_start), 0);
        check("wd_eng_reset", 32'(eng_if.eng_reset), 1);
        check("wd_busy", 32'(busy), 0);
        cmd_go = 1'b0;
        tick();
        cmd_go = 1'b1;
        repeat (3) tick();
        cmd_go = 1'b0;
        check("wd_go_ignored_err", 32'(timeout_err), 1);
        check("wd_go_ignored_busy", 32'(busy), 0);
        check("wd_go_ignored_init", init_cnt, 1);
        eng_hang  = 1'b0;
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        check("wd_abort_clears_err", 32'(timeout_err), 0);
        check("wd_abort_done", 32'(done), 0);
        for (int i = 2; i <= 5; i++) begin
            tick();
            check($sformatf("wd_abort_hold_c%0d", i), 32'(eng_if.eng_reset), 32'(i < 5));
        end
        check("wd_sb_drained", sb_q.size(), 0);
        repeat (2) tick();

        // Abort coinciding with completion of generation 1.
        cfg_buf_a_addr = 12'h300;
        cfg_buf_b_addr = 12'h600;
        cfg_gen_count  = 16'd3;
        push_pairs(12'h300, 12'h600, 2);
        abort_at_gen1 = 1'b1;
        go_pulse();
        guard = 0;
        while (!cmd_abort && guard < 200) begin
            tick();
            guard++;
        end
        check("ab_fired", 32'(cmd_abort), 1);
        tick();
        cmd_abort = 1'b0;
        check("ab_busy", 32'(busy), 0);
        check("ab_eng_reset", 32'(eng_if.eng_reset), 1);
        check("ab_eng_start", 32'(eng_if.eng_start), 0);
        check("ab_done", 32'(done), 0);
        check("ab_gen_done", 32'(gen_done), 1);
        repeat (5) tick();
        check("ab_idle_eng_reset", 32'(eng_if.eng_reset), 0);
        check("ab_idle_gen_done", 32'(gen_done), 1);
        check("ab_idle_done", 32'(done), 0);
        check("ab_start_pulses", start_cnt, 2);
        check("ab_sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gol_generation_sequencer.md
Name: gol_generation_sequencer

Overview:
- Sequences the Game of Life engine through N generations without HPS intervention per generation.
- Ping-pongs the engine's start and result addresses between two on-chip memory buffers.
- Runs the start/completed handshake and a timeout watchdog, and reports progress to HPS PIOs.
- Sits between the HPS PIO exports and the engine wrapper, replacing direct PIO drive of the engine's start, initialize, address and reset inputs.

Parameters:
ADDR_W, 12, on-chip memory address width
GEN_W, 16, generation counter width
TIMEOUT_W, 26, watchdog counter width
TIMEOUT, 50000000, cycles allowed per RUN or RELEASE phase before error (1 s at 50 MHz)
RESET_CYCLES, 4, cycles eng_reset is held after reset or abort

Ports:
fpga_clk_50  in  1  clock
hps_fpga_reset_n  in  1  asynchronous, active-low reset
cmd_go  in  1  PIO level; rising edge starts a run
cmd_abort  in  1  PIO level; abort, highest priority
cfg_buf_a_addr  in  ADDR_W  base of buffer A (initial board)
cfg_buf_b_addr  in  ADDR_W  base of buffer B
cfg_gen_count  in  GEN_W  generations to compute
eng_reset  out  1  active-high engine reset
eng_initialize  out  1  engine initialize strobe
eng_start  out  1  engine start level
eng_start_address  out  ADDR_W  source buffer for the current generation
eng_result_address  out  ADDR_W  destination buffer for the current generation
eng_completed  in  1  engine completion level
busy  out  1  run in progress
done  out  1  sticky; run finished
timeout_err  out  1  sticky; watchdog fired
gen_done  out  GEN_W  generations completed in the current or last run
result_sel  out  1  buffer holding the final board: 0 = A, 1 = B

Behaviour:

Reset:
- State ABORT, hold counter 0, eng_reset=1.
- All other outputs 0, addresses 0.
- The go-edge register resets to 1, so a go level that is already high after reset is not an edge.

States: ABORT, IDLE, INIT, SETUP, RUN, RELEASE, DONE, ERROR.

ABORT:
- eng_reset=1 for RESET_CYCLES cycles, then go to IDLE.
- busy=0, done=0.

IDLE / DONE:
- Wait for a go edge (cmd_go=1 and the previous sample was 0).
- On the edge:
  - Latch cfg_buf_a_addr, cfg_buf_b_addr and cfg_gen_count.
  - Clear done, gen_done and result_sel.
  - Load eng_start_address=A and eng_result_address=B.
- If the latched count is 0, go to DONE next cycle with done=1, gen_done=0, result_sel=0. Otherwise go to INIT.
- In DONE, done=1.

INIT:
- eng_initialize=1 for exactly one cycle, then go to SETUP.

SETUP:
- One cycle with addresses stable and eng_start=0; clear the watchdog; go to RUN.

RUN:
- eng_start=1 until eng_completed is sampled 1, then go to RELEASE.

RELEASE:
- eng_start=0; wait for eng_completed=0.
- Then, in the same transition:
  - gen_done increments.
  - The addresses swap.
  - result_sel toggles.
- If gen_done (new value) equals the latched count, go to DONE. Otherwise clear the watchdog and go to SETUP.

Buffer roles:
- Generation k (0-based) reads A and writes B if k is even; reads B and writes A if k is odd.
- After a run, result_sel = count[0].

Watchdog:
- Counts every cycle in RUN and RELEASE and is cleared on entry to SETUP.
- Reaching TIMEOUT goes to ERROR.

ERROR:
- timeout_err=1 (sticky), eng_start=0, eng_reset=1, busy=0.
- Go edges are ignored; the only exit is cmd_abort.

cmd_abort:
- From any state except ABORT, go to ABORT next cycle.
- Clears timeout_err and done; gen_done is retained.
- Abort wins over simultaneous completion, go or timeout.

Other rules:
- busy=1 in INIT, SETUP, RUN and RELEASE.
- Go edges while busy are ignored.
- Config inputs are only sampled on the go edge.
- eng_completed already high on entry to RUN counts as immediate completion.
- eng_initialize and eng_start are never asserted in the same cycle.
- gen_done saturates at its all-ones value; the count comparison uses the latched value.
- All outputs are registered.

Test Plan:
- Reset release -> eng_reset high for 4 cycles, then IDLE; cmd_go held high through reset produces no run.
- A=0x000, B=0x800, count=3, engine model completes 10 cycles after start and drops completed 2 cycles after start falls.
  - Start/result pairs must be (0x000,0x800), (0x800,0x000), (0x000,0x800).
  - One eng_initialize pulse before the first start.
  - Final state: done=1, gen_done=3, result_sel=1.
- count=0 with a go edge -> done=1 within 2 cycles, no eng_initialize or eng_start pulse, result_sel=0.
- TIMEOUT=100, engine never completes -> timeout_err=1 at RUN entry +100 cycles, eng_start=0, eng_reset=1.
  - A go edge is ignored.
  - cmd_abort clears timeout_err, and IDLE is reached after 4 reset cycles.
- cmd_abort asserted in the same cycle that eng_completed rises in generation 1 -> ABORT entered, gen_done stays 1, done=0.
- A go edge during RUN, and config changes mid-run, have no effect; the run finishes with the originally latched count and addresses.
